// File: rtl/tick_speed_controller.sv
`default_nettype none
// ============================================================================
// Module      : tick_speed_controller
// Description : Keeps a speed level (0..7) driven by three push buttons and
//               outputs the matching tick period, BASE_DELAY >> level, in
//               clock cycles for the falling-sand tick generator.
// Ports       : clk_i         - system clock
//               reset_i       - asynchronous active-low reset
//               controller_i  - buttons [0] faster, [1] slower, [2] restore
//               tick_delay_o  - registered cycles between simulation ticks
// Revision    : 1.0 - initial release
// ============================================================================
module tick_speed_controller #(
   parameter int unsigned BASE_DELAY    = 100_000_000,
   parameter int unsigned DEFAULT_LEVEL = 3,
   parameter int unsigned NUM_LEVELS    = 8
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [2:0]  controller_i,
   output logic [26:0] tick_delay_o
);

   localparam logic [26:0] c_BASE_DELAY  = 27'(BASE_DELAY);
   localparam logic [2:0]  c_DEFAULT_LVL = 3'(DEFAULT_LEVEL);
   localparam logic [2:0]  c_MAX_LVL     = 3'(NUM_LEVELS - 1);

   // Button conditioning: two synchronizer stages plus one history stage.
   logic [2:0]  r_sync1;
   logic [2:0]  r_sync2;
   logic [2:0]  r_hist;
   logic [2:0]  w_press;

   logic [2:0]  r_level;
   logic [2:0]  w_level_next;
   logic [26:0] w_delay_next;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
         r_hist  <= 3'b000;
      end else begin
         r_sync1 <= controller_i;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   // Rising edge only, so a held button yields exactly one press.
   assign w_press = r_sync2 & ~r_hist;

   always_comb begin
      w_level_next = r_level;
      if (w_press[2]) begin
         w_level_next = c_DEFAULT_LVL;
      end else if (w_press[0] && w_press[1]) begin
         w_level_next = r_level;
      end else if (w_press[0] && (r_level < c_MAX_LVL)) begin
         w_level_next = r_level + 3'd1;
      end else if (w_press[1] && (r_level != 3'd0)) begin
         w_level_next = r_level - 3'd1;
      end
   end

   // Delay is derived from the next level so it updates on the same edge as
   // the level register and never lags it by a cycle.
   assign w_delay_next = c_BASE_DELAY >> w_level_next;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_level      <= c_DEFAULT_LVL;
         tick_delay_o <= c_BASE_DELAY >> c_DEFAULT_LVL;
      end else begin
         r_level      <= w_level_next;
         tick_delay_o <= w_delay_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tick_speed_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_speed_controller
// Description : Self-checking bench for tick_speed_controller. Expected delays
//               are queued when a button press is driven and popped when the
//               output is due to change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_speed_controller;

   logic        clk_i;
   logic        reset_i;
   logic [2:0]  controller_i;
   logic [26:0] tick_delay_o;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int model_level;

   tick_speed_controller #(
      .BASE_DELAY    (100_000_000),
      .DEFAULT_LEVEL (3),
      .NUM_LEVELS    (8)
   ) u_dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .controller_i (controller_i),
      .tick_delay_o (tick_delay_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int delay_of(input int lvl);
      case (lvl)
         0: return 100_000_000;
         1: return 50_000_000;
         2: return 25_000_000;
         3: return 12_500_000;
         4: return 6_250_000;
         5: return 3_125_000;
         6: return 1_562_500;
         default: return 781_250;
      endcase
   endfunction

   task automatic model_apply(input logic [2:0] m);
      if (m[2])                         model_level = 3;
      else if (m[0] && m[1])            model_level = model_level;
      else if (m[0] && model_level < 7) model_level = model_level + 1;
      else if (m[1] && model_level > 0) model_level = model_level - 1;
   endtask

   task automatic do_reset();
      reset_i      = 1'b0;
      controller_i = 3'b000;
      model_level  = 3;
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
   endtask

   // Drives a one-cycle pulse and queues the expected result. Returns just
   // after edge N (the first edge that samples the pulse), input released.
   task automatic send_pulse(input logic [2:0] m);
      model_apply(m);
      exp_q.push_back(delay_of(model_level));
      @(negedge clk_i);
      controller_i = m;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      controller_i = 3'b000;
   endtask

   task automatic test_reset();
      reset_i      = 1'b0;
      controller_i = 3'b000;
      model_level  = 3;
      exp_q.delete();
      #12;
      total++;
      if (tick_delay_o !== 27'd12_500_000) begin
         bad++;
         $display("FAIL reset_held actual=%0d required=%0d", tick_delay_o, 12_500_000);
      end
      @(negedge clk_i);
      reset_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      total++;
      if (tick_delay_o !== 27'd12_500_000) begin
         bad++;
         $display("FAIL reset_release actual=%0d required=%0d", tick_delay_o, 12_500_000);
      end
   endtask

   task automatic test_faster();
      int stale;
      int e;
      for (int i = 0; i < 3; i++) begin
         stale = delay_of(model_level);
         send_pulse(3'b001);
         @(posedge clk_i); #1;
         total++;
         if (tick_delay_o !== 27'(stale)) begin
            bad++;
            $display("FAIL faster_early[%0d] actual=%0d required=%0d", i, tick_delay_o, stale);
         end
         @(posedge clk_i); #1;
         total++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         if (tick_delay_o !== 27'(e)) begin
            bad++;
            $display("FAIL faster[%0d] actual=%0d required=%0d", i, tick_delay_o, e);
         end
      end
   endtask

   task automatic test_saturate_high_and_hold();
      int e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send_pulse(3'b001);
         repeat (2) @(posedge clk_i);
         #1;
         total++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         if (tick_delay_o !== 27'(e)) begin
            bad++;
            $display("FAIL sat_high[%0d] actual=%0d required=%0d", i, tick_delay_o, e);
         end
      end
      total++;
      if (tick_delay_o !== 27'd781_250) begin
         bad++;
         $display("FAIL sat_high_final actual=%0d required=%0d", tick_delay_o, 781_250);
      end
      // Hold slower for 50 cycles: exactly one step.
      model_apply(3'b010);
      exp_q.push_back(delay_of(model_level));
      @(negedge clk_i);
      controller_i = 3'b010;
      repeat (3) @(posedge clk_i);
      #1;
      total++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (tick_delay_o !== 27'(e)) begin
         bad++;
         $display("FAIL hold_first_step actual=%0d required=%0d", tick_delay_o, e);
      end
      repeat (47) @(posedge clk_i);
      #1;
      total++;
      if (tick_delay_o !== 27'd1_562_500) begin
         bad++;
         $display("FAIL hold_no_repeat actual=%0d required=%0d", tick_delay_o, 1_562_500);
      end
      @(negedge clk_i);
      controller_i = 3'b000;
      repeat (5) @(posedge clk_i);
      #1;
      total++;
      if (tick_delay_o !== 27'd1_562_500) begin
         bad++;
         $display("FAIL hold_release actual=%0d required=%0d", tick_delay_o, 1_562_500);
      end
   endtask

   task automatic test_saturate_low_and_restore();
      int e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_pulse(3'b010);
         repeat (2) @(posedge clk_i);
         #1;
         total++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         if (tick_delay_o !== 27'(e)) begin
            bad++;
            $display("FAIL sat_low[%0d] actual=%0d required=%0d", i, tick_delay_o, e);
         end
      end
      total++;
      if (tick_delay_o !== 27'd100_000_000) begin
         bad++;
         $display("FAIL sat_low_final actual=%0d required=%0d", tick_delay_o, 100_000_000);
      end
      send_pulse(3'b100);
      repeat (2) @(posedge clk_i);
      #1;
      total++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (tick_delay_o !== 27'(e)) begin
         bad++;
         $display("FAIL restore actual=%0d required=%0d", tick_delay_o, e);
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] pats [3];
      int e;
      pats[0] = 3'b001;
      pats[1] = 3'b011;
      pats[2] = 3'b101;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_pulse(pats[i]);
         repeat (2) @(posedge clk_i);
         #1;
         total++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         if (tick_delay_o !== 27'(e)) begin
            bad++;
            $display("FAIL simult[%b] actual=%0d required=%0d", pats[i], tick_delay_o, e);
         end
      end
   endtask

   task automatic test_async_reset();
      int e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_pulse(3'b001);
         repeat (2) @(posedge clk_i);
         #1;
         void'(exp_q.pop_front());
      end
      total++;
      if (tick_delay_o !== 27'd1_562_500) begin
         bad++;
         $display("FAIL level6 actual=%0d required=%0d", tick_delay_o, 1_562_500);
      end
      @(posedge clk_i);
      #3;
      reset_i = 1'b0;
      #1;
      total++;
      if (tick_delay_o !== 27'd12_500_000) begin
         bad++;
         $display("FAIL async_reset actual=%0d required=%0d", tick_delay_o, 12_500_000);
      end
      // Button held across reset release counts as one press.
      model_level = 3;
      exp_q.delete();
      controller_i = 3'b001;
      model_apply(3'b001);
      exp_q.push_back(delay_of(model_level));
      @(negedge clk_i);
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      total++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      if (tick_delay_o !== 27'(e)) begin
         bad++;
         $display("FAIL held_through_reset actual=%0d required=%0d", tick_delay_o, e);
      end
      repeat (10) @(posedge clk_i);
      #1;
      total++;
      if (tick_delay_o !== 27'd6_250_000) begin
         bad++;
         $display("FAIL held_no_repeat actual=%0d required=%0d", tick_delay_o, 6_250_000);
      end
      controller_i = 3'b000;
   endtask

   initial begin
      test_reset();
      test_faster();
      test_saturate_high_and_hold();
      test_saturate_low_and_restore();
      test_simultaneous();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
